// File: rtl/det_pkg.sv
// det_pkg: shared FSM state type, width helpers and default pattern for det_sched
package det_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
  localparam logic [2:0] DEF_PATTERN = 3'b101;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/pat_detect.sv
// pat_detect: bit-serial PAT_LEN-bit pattern matcher; DET_NONOVERLAP_EN selects non-overlapping matches
module pat_detect #(
  parameter int PAT_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               bit_vld,
  input  logic               bit_in,
  input  logic [PAT_LEN-1:0] pattern,
  output logic               match
);
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);
  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  assign match = bit_vld && (fill == FULL) && ({hist, bit_in} == pattern);
  // history window plus a saturating count of valid prior bits since the last clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_vld) begin
`ifdef DET_NONOVERLAP_EN
      hist <= match ? '0 : (PAT_LEN-1)'({hist, bit_in});
      fill <= match ? '0 : (fill == FULL) ? fill : fill + 1'b1;
`else
      hist <= (PAT_LEN-1)'({hist, bit_in});
      fill <= (fill == FULL) ? fill : fill + 1'b1;
`endif
    end
endmodule

// File: rtl/det_sched.sv
// det_sched: round-robin scheduler feeding words MSB-first into pat_detect; DET_NONOVERLAP_EN selects non-overlapping counts
module det_sched import det_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8,
  parameter int PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]         gnt,
  input  logic                     cfg_we,
  input  logic [PAT_LEN-1:0]       cfg_pat,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [id_w(N_REQ)-1:0]   res_id,
  output logic [cnt_w(WIDTH)-1:0]  res_count
);
  localparam int IW = id_w(N_REQ);
  localparam int CW = cnt_w(WIDTH);
  state_t             state;
  logic [IW-1:0]      ptr, win, id;
  logic [WIDTH-1:0]   word;
  logic [CW-1:0]      bcnt, mcnt;
  logic [PAT_LEN-1:0] pat;
  logic               take, match;
  assign take      = (state == IDLE) && |req;
  assign gnt       = take ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
  assign busy      = state != IDLE;
  assign res_valid = state == REPORT;
  // round-robin pick: scan from ptr upward, first requester found wins
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N_REQ]) win = IW'((int'(ptr) + k) % N_REQ);
  end
  pat_detect #(.PAT_LEN(PAT_LEN)) u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (take),
    .bit_vld (state == SHIFT),
    .bit_in  (word[WIDTH-1]),
    .pattern (pat),
    .match   (match)
  );
  // control FSM: grant and capture, shift WIDTH bits, hold result until accepted
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      word      <= '0;
      bcnt      <= '0;
      mcnt      <= '0;
      pat       <= PATTERN;
      res_id    <= '0;
      res_count <= '0;
    end else
      case (state)
        IDLE: begin
          if (cfg_we) pat <= cfg_pat;
          if (take) begin
            word  <= data_in[win*WIDTH +: WIDTH];
            id    <= win;
            ptr   <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
            bcnt  <= '0;
            mcnt  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          word <= word << 1;
          bcnt <= bcnt + 1'b1;
          mcnt <= mcnt + CW'(match);
          if (bcnt == CW'(WIDTH - 1)) begin
            res_id    <= id;
            res_count <= mcnt + CW'(match);
            state     <= REPORT;
          end
        end
        REPORT: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_det_sched.sv
// tb_det_sched: directed scoreboard bench for det_sched (N_REQ=2, WIDTH=8, PAT_LEN=3)
module tb_det_sched;
  logic        clk = 0, rst = 0;
  logic [1:0]  req = '0;
  logic [15:0] data_in = '0;
  logic [1:0]  gnt;
  logic        cfg_we = 0;
  logic [2:0]  cfg_pat = '0;
  logic        busy, res_valid, res_ready = 0;
  logic [0:0]  res_id;
  logic [3:0]  res_count;
  int          total = 0, bad = 0, ptr_m = 0;
  logic [2:0]  pat_m = 3'b101;
  typedef struct packed {logic [0:0] id; logic [3:0] cnt;} exp_t;
  exp_t        sb[$];

  always #5 clk = ~clk;

  det_sched dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_count(res_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input logic [7:0] w, input logic [2:0] p);
    int c = 0, f = 0;
    logic [2:0] h = '0;
    for (int i = 7; i >= 0; i--) begin
      h = {h[1:0], w[i]};
      f++;
      if (f >= 3 && h == p) begin
        c++;
`ifdef DET_NONOVERLAP_EN
        f = 0;
`endif
      end
    end
    return c;
  endfunction

  function automatic int pick(input logic [1:0] r);
    for (int k = 0; k < 2; k++) if (r[(ptr_m + k) % 2]) return (ptr_m + k) % 2;
    return 0;
  endfunction

  task automatic cfg(input logic [2:0] p);
    @(negedge clk); cfg_we = 1; cfg_pat = p;
    @(negedge clk); cfg_we = 0; pat_m = p;
  endtask

  task automatic run(input logic [1:0] r, input logic [7:0] w0, input logic [7:0] w1,
                     input int hold, input bit spur);
    int n, win;
    exp_t e, a;
    @(negedge clk); req = r; data_in = {w1, w0}; #1;
    win = pick(r);
    chk("gnt", gnt, 32'(2'b01 << win));
    e.id = 1'(win);
    e.cnt = 4'(model(win ? w1 : w0, pat_m));
    sb.push_back(e);
    ptr_m = (win + 1) % 2;
    @(negedge clk); req = '0;
    chk("busy", busy, 1);
    n = 0;
    while (!res_valid && n < 40) begin
      if (spur && n == 2) begin cfg_we = 1; cfg_pat = ~pat_m; end else cfg_we = 0;
      @(negedge clk);
      n++;
    end
    cfg_we = 0;
    chk("latency", n, 8);
    if (hold > 0) begin
      req = 2'b01;
      for (int i = 0; i < hold; i++) begin
        #1;
        chk("hold_gnt", gnt, 0);
        chk("hold_valid", res_valid, 1);
        chk("hold_id", res_id, sb[0].id);
        chk("hold_cnt", res_count, sb[0].cnt);
        @(negedge clk);
      end
    end
    a = sb.pop_front();
    chk("res_valid", res_valid, 1);
    chk("res_id", res_id, a.id);
    chk("res_count", res_count, a.cnt);
    res_ready = 1;
    @(negedge clk); res_ready = 0; #1;
    chk("idle", {busy, res_valid}, 0);
    chk("keep_id", res_id, a.id);
    chk("keep_cnt", res_count, a.cnt);
    if (hold > 0) begin
      chk("regrant", gnt, 2'b01);
      req = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_cnt", res_count, 0);
    @(negedge clk); rst = 1;
    run(2'b01, 8'b10101010, 8'h00, 0, 0);
    run(2'b11, 8'b01010100, 8'b10110101, 0, 0);
    run(2'b11, 8'b10100000, 8'b00101101, 0, 0);
    run(2'b11, 8'b11011011, 8'b10101101, 0, 0);
    run(2'b11, 8'b00010100, 8'b01110101, 0, 0);
    cfg(3'b111);
    run(2'b01, 8'b11110000, 8'h00, 0, 1);
    run(2'b10, 8'h00, 8'b11110000, 0, 0);
    run(2'b10, 8'h00, 8'b11100111, 5, 0);
    @(negedge clk); req = 2'b01; data_in = {8'h00, 8'hff}; #1;
    chk("pre_rst_gnt", gnt, 2'b01);
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);
    rst = 0; #1;
    chk("mid_busy", busy, 0);
    chk("mid_valid", res_valid, 0);
    chk("mid_id", res_id, 0);
    chk("mid_cnt", res_count, 0);
    chk("mid_gnt", gnt, 0);
    ptr_m = 0;
    pat_m = 3'b101;
    @(negedge clk); rst = 1;
    run(2'b10, 8'h00, 8'b00000101, 0, 0);
    run(2'b11, 8'b00000000, 8'b10100000, 0, 0);
    run(2'b01, 8'b00000000, 8'h00, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/det_sched.md
Name: det_sched

Overview:
- Scheduler/controller for a shared serial pattern detector.
- Up to N_REQ requesters each submit a parallel WIDTH-bit word through a req/gnt handshake.
- A round-robin arbiter picks one requester. The word is shifted MSB-first, one bit per clock, through a programmable PAT_LEN-bit pattern detector, and the matches are counted.
- The count and the winning requester ID are returned on a valid/ready result port. Sits between the host-side requesters and the bit-serial detection datapath.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- WIDTH, 8, bits per submitted word (PAT_LEN..32)
- PAT_LEN, 3, pattern length in bits (2..8)
- PATTERN, 3'b101, reset value of the pattern register

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request, held until granted
- data_in  in  N_REQ*WIDTH  requester words; slice i = data_in[i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, one cycle
- cfg_we  in  1  pattern write strobe
- cfg_pat  in  PAT_LEN  new pattern value
- busy  out  1  high in every state except IDLE
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_id  out  clog2(N_REQ)  requester that owns the result
- res_count  out  clog2(WIDTH+1)  number of matches in the word

Behaviour:
- Reset (rst low, async): state=IDLE; gnt=0; busy=0; res_valid=0; res_id=0; res_count=0; pattern=PATTERN; shift/history/bit counter=0; RR pointer selects requester 0 as top priority. Reset mid-shift or mid-report discards the word and the result.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - gnt is combinational and one-hot for the RR winner whenever any req is high, else 0.
  - On that edge: capture the winner's word, latch the winner ID, clear the detector history and match counter, go to SHIFT.
  - RR priority starts at (last granted + 1) mod N_REQ.
- SHIFT:
  - One bit per edge, MSB first, WIDTH edges exactly.
  - The detector compares the last PAT_LEN bits against the pattern.
  - A match needs at least PAT_LEN valid history bits since the clear; each match increments the count.
  - After the WIDTH-th bit: go to REPORT, res_valid=1.
  - Latency: res_valid rises WIDTH cycles after the grant edge.
- REPORT:
  - res_valid, res_id and res_count are held stable until res_valid && res_ready.
  - On that edge: go to IDLE, res_valid=0. res_id and res_count keep their last values.
  - No same-cycle re-grant: requests pending during REPORT are granted in the first IDLE cycle.
- Requester rules:
  - A requester must hold req and its data slice stable until gnt, then deassert req or present a new word.
  - req changes during SHIFT or REPORT are ignored.
- Config:
  - cfg_we takes effect only in IDLE; it is ignored when busy.
  - If cfg_we and a grant fall in the same IDLE cycle, the new pattern applies to the granted word.
- Arithmetic: the count cannot overflow, because the maximum is WIDTH-PAT_LEN+1 and fits in clog2(WIDTH+1) bits. No detection across word boundaries.

Optional Feature:
- Macro: DET_NONOVERLAP_EN.
- Defined: after each match the detector history clears, so the next match needs PAT_LEN fresh bits (non-overlapping count).
- Undefined: history keeps sliding (overlapping count).

Decomposition:
- Package det_pkg holds:
  - state enum {IDLE, SHIFT, REPORT}
  - ID-width and count-width localparam functions (clog2)
  - default PATTERN constant
- Sub-module pat_detect holds the bit-serial detector:
  - inputs: clk, rst, clr, bit_vld, bit_in, pattern
  - output: match pulse
  - contains the history shift register, the fill counter and the DET_NONOVERLAP_EN logic.
- det_sched keeps the arbiter, FSM, word shifter and match counter.

Test Plan:
- Reset, req[0]=1 with word 8'b10101010, pattern 101 → gnt=2'b01 in the first cycle; res_valid after 8 cycles; res_id=0; res_count=3 (2 with DET_NONOVERLAP_EN).
- req=2'b11 together, both held, then re-requested every time → grants alternate 0,1,0,1; res_id follows the same order.
- cfg_pat=3'b111 written in IDLE, word 8'b11110000 → res_count=2 (1 with DET_NONOVERLAP_EN). cfg_we pulsed during SHIFT → pattern unchanged, verified by the next word's count.
- res_ready held low for 5 cycles in REPORT → res_valid, res_id and res_count stay stable and gnt stays 0 despite a pending req. res_ready=1 → IDLE, then grant on the next cycle.
- rst pulsed low at shift bit 4 → all outputs return to reset values at once. The next word 8'b00000101 with pattern 101 → res_count=1, res_id = the newly granted requester.
- Word 8'b00000000, pattern 101 → res_count=0; res_valid still asserted on time.
